// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchronise, debounce, press/release,
// long-press and auto-repeat detection, with events held until take_en accepts them.
module button_conditioner #(
  parameter int             N             = 4,
  parameter int             CTR_WIDTH     = 18,
  parameter logic [N-1:0]   INVERT        = '0,
  parameter int             LONG_CYCLES   = 12_000_000,
  parameter int             REPEAT_CYCLES = 3_000_000,
  parameter logic [N-1:0]   REPEAT_EN     = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] btn_raw,
  input  logic         take_en,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] long_o,
  output logic [N-1:0] repeat_o,
  output logic [N-1:0] overrun_o
);

  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W     = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    PARKED
  } hold_state_t;

  logic [N-1:0] sync_meta;
  logic [N-1:0] sync_q;

  // Inversion happens before the synchroniser, so its reset value of 0 is the released state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= btn_raw ^ INVERT;
      sync_q    <= sync_meta;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic [CTR_WIDTH-1:0] db_cnt;
    logic                 level_q;
    logic [HOLD_W-1:0]    hold_cnt;
    hold_state_t          hold_state;
    logic                 press_q, release_q, long_q, repeat_q, overrun_q;
    logic                 flip, rise, fall, long_ev, repeat_ev;

    always_comb begin
      flip      = (sync_q[i] != level_q) && (&db_cnt);
      rise      = flip && sync_q[i];
      fall      = flip && !sync_q[i];
      long_ev   = (hold_state == HOLD) && (hold_cnt == LONG_LAST) && !fall;
      repeat_ev = (hold_state == REPEAT) && (hold_cnt == REPEAT_LAST) && !fall;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (sync_q[i] == level_q) begin
        db_cnt <= '0;
      end else if (&db_cnt) begin
        db_cnt  <= '0;
        level_q <= sync_q[i];
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    // Edges override the hold sequence; PARKED stops counting until release.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        hold_state <= IDLE;
        hold_cnt   <= '0;
      end else if (fall) begin
        hold_state <= IDLE;
        hold_cnt   <= '0;
      end else if (rise) begin
        hold_state <= HOLD;
        hold_cnt   <= '0;
      end else begin
        case (hold_state)
          HOLD: begin
            if (hold_cnt == LONG_LAST) begin
              hold_cnt   <= '0;
              hold_state <= REPEAT_EN[i] ? REPEAT : PARKED;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (hold_cnt == REPEAT_LAST) hold_cnt <= '0;
            else                         hold_cnt <= hold_cnt + 1'b1;
          end
          default: hold_cnt <= '0;
        endcase
      end
    end

    // A same-cycle take and new event keeps the bit set without counting an overrun.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        press_q   <= rise      | (press_q   & ~take_en);
        release_q <= fall      | (release_q & ~take_en);
        long_q    <= long_ev   | (long_q    & ~take_en);
        repeat_q  <= repeat_ev | (repeat_q  & ~take_en);
        overrun_q <= overrun_q | (~take_en & ((rise & press_q) | (fall & release_q) |
                                              (long_ev & long_q) | (repeat_ev & repeat_q)));
      end
    end

    assign level_o[i]   = level_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
    assign long_o[i]    = long_q;
    assign repeat_o[i]  = repeat_q;
    assign overrun_o[i] = overrun_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: table of stepped vectors plus hand-written
// sequences for bounce, slow consumer, overrun, reset and take/event collisions.
module tb_button_conditioner;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] btn_raw;
  logic         take_en;
  logic [N-1:0] level_o, press_o, release_o, long_o, repeat_o, overrun_o;
  logic [11:0]  got_vec;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string      name;
    logic [1:0] raw;
    logic       take;
    int         steps;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[15];

  button_conditioner #(
    .N(2), .CTR_WIDTH(2), .INVERT(2'b01), .LONG_CYCLES(10),
    .REPEAT_CYCLES(4), .REPEAT_EN(2'b10)
  ) dut (
    .clk(clk), .resetn(resetn), .btn_raw(btn_raw), .take_en(take_en),
    .level_o(level_o), .press_o(press_o), .release_o(release_o),
    .long_o(long_o), .repeat_o(repeat_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  assign got_vec = {level_o, press_o, release_o, long_o, repeat_o, overrun_o};

  function automatic logic [11:0] exp_vec(input logic [1:0] lvl, input logic [1:0] prs,
                                          input logic [1:0] rel, input logic [1:0] lng,
                                          input logic [1:0] rpt, input logic [1:0] ovr);
    return {lvl, prs, rel, lng, rpt, ovr};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] raw, input logic take, input int n);
    btn_raw = raw;
    take_en = take;
    step(n);
  endtask

  task automatic check_output(input string name, input logic [11:0] exp);
    tests_run++;
    if (got_vec !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b expected %b (lvl,prs,rel,lng,rpt,ovr)", name, got_vec, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  initial begin
    int   e;
    logic seen;

    // Clean press and hold on channel 1 with take_en tied high
    vecs[0]  = '{"s1_settling",     2'b11, 1'b1, 5, exp_vec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[1]  = '{"s1_press",        2'b11, 1'b1, 1, exp_vec(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[2]  = '{"s1_press_width",  2'b11, 1'b1, 1, exp_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[3]  = '{"s1_before_long",  2'b11, 1'b1, 8, exp_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[4]  = '{"s1_long",         2'b11, 1'b1, 1, exp_vec(2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00)};
    vecs[5]  = '{"s1_long_width",   2'b11, 1'b1, 1, exp_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[6]  = '{"s1_before_rep1",  2'b11, 1'b1, 2, exp_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[7]  = '{"s1_repeat1",      2'b11, 1'b1, 1, exp_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00)};
    vecs[8]  = '{"s1_repeat_width", 2'b11, 1'b1, 1, exp_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[9]  = '{"s1_repeat2",      2'b11, 1'b1, 3, exp_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00)};
    vecs[10] = '{"s1_repeat3",      2'b01, 1'b1, 4, exp_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00)};
    vecs[11] = '{"s1_before_rel",   2'b01, 1'b1, 1, exp_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[12] = '{"s1_release",      2'b01, 1'b1, 1, exp_vec(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00)};
    vecs[13] = '{"s1_release_width",2'b01, 1'b1, 1, exp_vec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[14] = '{"s1_no_more_rep",  2'b01, 1'b1, 4, exp_vec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};

    resetn  = 1'b0;
    btn_raw = 2'b01;
    take_en = 1'b1;
    #2;
    check_output("reset_state", 12'd0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step(8);
    check_output("idle_after_reset", 12'd0);

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].raw, vecs[i].take, vecs[i].steps);
      check_output(vecs[i].name, vecs[i].exp);
    end

    // Channel 0 is active-low: 3-cycle low glitches must never reach the level
    for (int r = 0; r < 5; r++) begin
      seen = 1'b0;
      for (int s = 0; s < 6; s++) begin
        apply_stimulus((s < 3) ? 2'b00 : 2'b01, 1'b1, 1);
        if (level_o[0] || press_o[0]) seen = 1'b1;
      end
      check_bit($sformatf("s2_bounce%0d", r), seen, 1'b0);
    end
    apply_stimulus(2'b00, 1'b1, 5);
    check_output("s2_pre_level", 12'd0);
    apply_stimulus(2'b00, 1'b1, 1);
    check_output("s2_press", exp_vec(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    apply_stimulus(2'b00, 1'b1, 9);
    check_output("s2_before_long", exp_vec(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    apply_stimulus(2'b00, 1'b1, 1);
    check_output("s2_long", exp_vec(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    seen = 1'b0;
    for (int s = 0; s < 20; s++) begin
      apply_stimulus(2'b00, 1'b1, 1);
      if (long_o[0] || repeat_o[0]) seen = 1'b1;
    end
    check_bit("s2_no_repeat", seen, 1'b0);
    apply_stimulus(2'b01, 1'b1, 6);
    check_output("s2_release", exp_vec(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    apply_stimulus(2'b01, 1'b1, 1);
    check_output("s2_idle", 12'd0);

    // Slow consumer: take_en one cycle in eight; repeat at edge 24 collides with a take
    for (int k = 0; k < 40; k++) begin
      apply_stimulus((k < 21) ? 2'b11 : 2'b01, (k % 8) == 7, 1);
      e = k + 1;
      check_output($sformatf("s3_edge%0d", e),
                   exp_vec({(e >= 6 && e <= 26), 1'b0}, {(e >= 6 && e <= 7), 1'b0},
                           {(e >= 27 && e <= 31), 1'b0}, {(e >= 16 && e <= 23), 1'b0},
                           {(e >= 20 && e <= 31), 1'b0}, 2'b00));
    end

    // Overrun: second press while the first is still pending
    apply_stimulus(2'b11, 1'b0, 6);
    check_output("s4_press1", exp_vec(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    apply_stimulus(2'b01, 1'b0, 5);
    check_output("s4_before_rel", exp_vec(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    apply_stimulus(2'b01, 1'b0, 1);
    check_output("s4_release", exp_vec(2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
    apply_stimulus(2'b11, 1'b0, 5);
    check_output("s4_before_press2", exp_vec(2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
    apply_stimulus(2'b11, 1'b0, 1);
    check_output("s4_overrun", exp_vec(2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10));
    apply_stimulus(2'b11, 1'b1, 1);
    check_output("s4_taken", exp_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));

    // Reset asynchronously while in REPEAT with long and repeat pending
    apply_stimulus(2'b11, 1'b1, 9);
    check_output("s5_long", exp_vec(2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10));
    apply_stimulus(2'b11, 1'b0, 4);
    check_output("s5_pending", exp_vec(2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10));
    #2;
    resetn = 1'b0;
    #1;
    check_output("s5_async_reset", 12'd0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    apply_stimulus(2'b11, 1'b1, 5);
    check_output("s5_pre_press", 12'd0);
    apply_stimulus(2'b11, 1'b1, 1);
    check_output("s5_repress", exp_vec(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    apply_stimulus(2'b11, 1'b1, 1);
    check_output("s5_repress_width", exp_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
